inst_fetch: RTL

- Instruction-fetch stage. Directly upstream of the FI_ID pipeline register.
- Owns the fetch PC and runs a req/ack handshake with instruction memory, which may have variable latency.
- Delivers registered {pc, inst, valid} to FI_ID.
- Honours the hazard unit's pause. Honours branch/jump redirects from the execute stage, including redirects that land while a memory access is outstanding.

---
 rtl/inst_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a req/ack handshake with a
// variable-latency instruction memory and delivers {pc, inst, valid} to FI_ID.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] redir_q;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic [31:0] redir_tgt;
    logic        slot_free;
    logic        unused_redir_lsb;

    assign redir_tgt        = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign slot_free        = ~valid_o | ~pause;

    assign imem_req  = ~rst & ((state == S_FETCH) | (state == S_DRAIN));
    assign imem_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            addr_q    <= RESET_PC;
            redir_q   <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
            pc_o      <= '0;
            inst_o    <= '0;
            valid_o   <= 1'b0;
        end else begin
            // The slot empties when consumed; the state cases below reload it.
            if (!pause) begin
                valid_o <= 1'b0;
                inst_o  <= '0;
            end
            if (redirect_en) begin
                valid_o   <= 1'b0;
                inst_o    <= '0;
                skid_pc   <= '0;
                skid_inst <= '0;
            end

            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_en) begin
                            addr_q <= redir_tgt;
                        end else if (slot_free) begin
                            pc_o    <= addr_q;
                            inst_o  <= imem_rdata;
                            valid_o <= 1'b1;
                            addr_q  <= addr_q + 32'd4;
                        end else begin
                            skid_pc   <= addr_q;
                            skid_inst <= imem_rdata;
                            addr_q    <= addr_q + 32'd4;
                            state     <= S_HOLD;
                        end
                    end else if (redirect_en) begin
                        // Keep addr_q stable for the in-flight access; retarget after its ack.
                        redir_q <= redir_tgt;
                        state   <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (redirect_en) begin
                        addr_q <= redir_tgt;
                        state  <= S_FETCH;
                    end else if (!pause) begin
                        pc_o    <= skid_pc;
                        inst_o  <= skid_inst;
                        valid_o <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        addr_q <= redirect_en ? redir_tgt : redir_q;
                        state  <= S_FETCH;
                    end else if (redirect_en) begin
                        redir_q <= redir_tgt;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
